// File: rtl/dmem_map_pkg.sv
// Address map and shared helpers for the core's data-memory responder:
// window bases, MMIO register offsets, CON_STAT bit positions and the masked-merge rule.
package dmem_map_pkg;

  localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h0001_0000;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

  localparam logic [11:0] OFF_CON_TX      = 12'h000;
  localparam logic [11:0] OFF_CON_STAT    = 12'h004;
  localparam logic [11:0] OFF_MTIME_LO    = 12'h008;
  localparam logic [11:0] OFF_MTIME_HI    = 12'h00C;
  localparam logic [11:0] OFF_MTIMECMP_LO = 12'h010;
  localparam logic [11:0] OFF_MTIMECMP_HI = 12'h014;

  localparam int STAT_FULL_BIT  = 16;
  localparam int STAT_EMPTY_BIT = 17;
  localparam int STAT_OVF_BIT   = 24;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_NONE
  } region_e;

  // Bits selected by wmask take wdata; the rest keep the old value.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [31:0] wmask);
    return (old_word & ~wmask) | (wdata & wmask);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Single-cycle data-memory port plus the console drain handshake.
// master = core/sink side, slave = dmem_responder.
interface dmem_responder_if;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [31:0] i_mem_wmask;
  logic        i_mem_we;
  logic [31:0] o_mem_rdata;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready;

  modport master (
    output i_mem_addr, i_mem_wdata, i_mem_wmask, i_mem_we, i_tx_ready,
    input  o_mem_rdata, o_tx_valid, o_tx_data
  );

  modport slave (
    input  i_mem_addr, i_mem_wdata, i_mem_wmask, i_mem_we, i_tx_ready,
    output o_mem_rdata, o_tx_valid, o_tx_data
  );
endinterface

// File: rtl/dmem_responder_fifo.sv
// Generic synchronous FIFO (module sync_fifo). A push while full is accepted only
// when a pop happens in the same cycle; otherwise it is silently dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_dout  = mem_q[rd_ptr_q];

  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_din;
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder for the core's single-cycle data port: word RAM, console TX FIFO and a
// 64-bit machine timer. Reads are combinational and side-effect free; writes commit at posedge.
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT,
  parameter int          DMEM_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  dmem_responder_if.slave   bus,
  output logic              o_timer_irq,
  output logic              o_bad_write
);

  localparam int          IDX_W      = $clog2(DMEM_WORDS);
  localparam int          CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

  logic [31:0]       ram_off;
  logic [IDX_W-1:0]  ram_idx;
  logic [11:0]       mmio_off;
  region_e           region;
  logic              unused_ram_off_lsbs;

  assign ram_off  = bus.i_mem_addr - DMEM_BASE;
  assign ram_idx  = ram_off[IDX_W+1:2];
  assign mmio_off = {bus.i_mem_addr[11:2], 2'b00};
  assign unused_ram_off_lsbs = ^ram_off[1:0];

  // Unsigned offset compare catches addresses below the base via wrap-around.
  always_comb begin
    region = REGION_NONE;
    if (ram_off < DMEM_BYTES)                              region = REGION_RAM;
    else if (bus.i_mem_addr[31:12] == MMIO_BASE[31:12])    region = REGION_MMIO;
  end

  logic mmio_we, ram_we;
  logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;
  logic con_push, con_pop, ovf_set, ovf_clr;

  assign ram_we      = bus.i_mem_we && (region == REGION_RAM);
  assign mmio_we     = bus.i_mem_we && (region == REGION_MMIO);
  assign wr_mtime_lo = mmio_we && (mmio_off == OFF_MTIME_LO);
  assign wr_mtime_hi = mmio_we && (mmio_off == OFF_MTIME_HI);
  assign wr_cmp_lo   = mmio_we && (mmio_off == OFF_MTIMECMP_LO);
  assign wr_cmp_hi   = mmio_we && (mmio_off == OFF_MTIMECMP_HI);
  assign con_push    = mmio_we && (mmio_off == OFF_CON_TX) && (|bus.i_mem_wmask[7:0]);
  assign ovf_clr     = mmio_we && (mmio_off == OFF_CON_STAT) &&
                       bus.i_mem_wmask[STAT_OVF_BIT] && bus.i_mem_wdata[STAT_OVF_BIT];

  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       fifo_dout;

  assign con_pop = !fifo_empty && bus.i_tx_ready;
  assign ovf_set = con_push && fifo_full && !con_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (con_push),
    .i_din   (bus.i_mem_wdata[7:0]),
    .i_pop   (con_pop),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign bus.o_tx_valid = !fifo_empty;
  assign bus.o_tx_data  = fifo_dout;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        overflow_q, overflow_d;
  logic        irq_q, irq_d;
  logic        bad_write_q, bad_write_d;

  always_comb begin
    mtime_d = mtime_q + 64'd1;
    if (wr_mtime_lo)
      mtime_d = {mtime_q[63:32], merge_word(mtime_q[31:0], bus.i_mem_wdata, bus.i_mem_wmask)};
    else if (wr_mtime_hi)
      mtime_d = {merge_word(mtime_q[63:32], bus.i_mem_wdata, bus.i_mem_wmask), mtime_q[31:0]};

    mtimecmp_d = mtimecmp_q;
    if (wr_cmp_lo)
      mtimecmp_d[31:0]  = merge_word(mtimecmp_q[31:0], bus.i_mem_wdata, bus.i_mem_wmask);
    if (wr_cmp_hi)
      mtimecmp_d[63:32] = merge_word(mtimecmp_q[63:32], bus.i_mem_wdata, bus.i_mem_wmask);

    // A drop in the same cycle as a W1C must leave the flag set.
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (ovf_set) overflow_d = 1'b1;

    irq_d       = (mtime_q >= mtimecmp_q);
    bad_write_d = bus.i_mem_we && (region == REGION_NONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      overflow_q  <= 1'b0;
      irq_q       <= 1'b0;
      bad_write_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      overflow_q  <= overflow_d;
      irq_q       <= irq_d;
      bad_write_q <= bad_write_d;
    end
  end

  assign o_timer_irq = irq_q;
  assign o_bad_write = bad_write_q;

  logic [31:0] ram_q [DMEM_WORDS];

  always_ff @(posedge i_clk) begin
    if (ram_we) ram_q[ram_idx] <= merge_word(ram_q[ram_idx], bus.i_mem_wdata, bus.i_mem_wmask);
  end

  logic [31:0] con_stat;

  always_comb begin
    con_stat                 = '0;
    con_stat[7:0]            = 8'(fifo_count);
    con_stat[STAT_FULL_BIT]  = fifo_full;
    con_stat[STAT_EMPTY_BIT] = fifo_empty;
    con_stat[STAT_OVF_BIT]   = overflow_q;
  end

  always_comb begin
    bus.o_mem_rdata = '0;
    case (region)
      REGION_RAM: bus.o_mem_rdata = ram_q[ram_idx];
      REGION_MMIO: begin
        case (mmio_off)
          OFF_CON_STAT:    bus.o_mem_rdata = con_stat;
          OFF_MTIME_LO:    bus.o_mem_rdata = mtime_q[31:0];
          OFF_MTIME_HI:    bus.o_mem_rdata = mtime_q[63:32];
          OFF_MTIMECMP_LO: bus.o_mem_rdata = mtimecmp_q[31:0];
          OFF_MTIMECMP_HI: bus.o_mem_rdata = mtimecmp_q[63:32];
          default:         bus.o_mem_rdata = '0;
        endcase
      end
      default: bus.o_mem_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed + randomized bench for dmem_responder against a queue/array reference model
// of the memory map (RAM words, console byte queue, 64-bit timer).
module tb_dmem_responder;

  localparam int          DW = 4096;
  localparam int          FD = 8;
  localparam logic [31:0] DB = 32'h0001_0000;
  localparam logic [31:0] MB = 32'h1000_0000;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  logic o_timer_irq, o_bad_write;

  always #5 i_clk = ~i_clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .DMEM_BASE  (DB),
    .DMEM_WORDS (DW),
    .MMIO_BASE  (MB),
    .FIFO_DEPTH (FD)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .bus         (bus),
    .o_timer_irq (o_timer_irq),
    .o_bad_write (o_bad_write)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  fifo_m [$];
  logic [31:0] ram_m [int];
  logic [63:0] mtime_m, cmp_m;
  bit          ovf_m, irq_m, badw_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [31:0] m);
    return (o & ~m) | (d & m);
  endfunction

  // 0 = RAM, 1 = MMIO, 2 = unmapped
  function automatic int region_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - DB;
    if (o < 32'(DW * 4)) return 0;
    if (a[31:12] == MB[31:12]) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    case (region_of(a))
      0: begin
        idx = int'((a - DB) >> 2);
        return ram_m.exists(idx) ? ram_m[idx] : 32'hxxxx_xxxx;
      end
      1: begin
        case ({a[11:2], 2'b00})
          12'h004: return {7'b0, ovf_m, 6'b0, fifo_m.size() == 0, fifo_m.size() == FD,
                           8'b0, 8'(fifo_m.size())};
          12'h008: return mtime_m[31:0];
          12'h00C: return mtime_m[63:32];
          12'h010: return cmp_m[31:0];
          12'h014: return cmp_m[63:32];
          default: return 32'h0;
        endcase
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    fifo_m.delete();
    ovf_m   = 1'b0;
    irq_m   = 1'b0;
    badw_m  = 1'b0;
    mtime_m = 64'h0;
    cmp_m   = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  // Advance the model across one clock edge using the inputs held during that cycle.
  task automatic model_update(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] m, input logic ready);
    int          r;
    logic [11:0] off;
    bit          pop, push, full, drop, clr;
    int          idx;
    logic [31:0] old;
    r    = region_of(a);
    off  = {a[11:2], 2'b00};
    pop  = (fifo_m.size() > 0) && ready;
    push = we && r == 1 && off == 12'h000 && (|m[7:0]);
    full = (fifo_m.size() == FD);
    drop = push && full && !pop;
    clr  = we && r == 1 && off == 12'h004 && m[24] && d[24];
    irq_m  = (mtime_m >= cmp_m);
    badw_m = we && r == 2;
    if (pop) void'(fifo_m.pop_front());
    if (push && !drop) fifo_m.push_back(d[7:0]);
    if (drop) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    if (we && r == 1 && off == 12'h008)      mtime_m[31:0]  = merge(mtime_m[31:0], d, m);
    else if (we && r == 1 && off == 12'h00C) mtime_m[63:32] = merge(mtime_m[63:32], d, m);
    else                                     mtime_m        = mtime_m + 64'd1;
    if (we && r == 1 && off == 12'h010) cmp_m[31:0]  = merge(cmp_m[31:0], d, m);
    if (we && r == 1 && off == 12'h014) cmp_m[63:32] = merge(cmp_m[63:32], d, m);
    if (we && r == 0) begin
      idx = int'((a - DB) >> 2);
      old = ram_m.exists(idx) ? ram_m[idx] : 32'hxxxx_xxxx;
      ram_m[idx] = merge(old, d, m);
    end
  endtask

  task automatic compare_outputs();
    logic [31:0] exp_rd;
    check("tx_valid", 64'(bus.o_tx_valid), 64'(fifo_m.size() > 0));
    if (fifo_m.size() > 0) check("tx_data", 64'(bus.o_tx_data), 64'(fifo_m[0]));
    check("timer_irq", 64'(o_timer_irq), 64'(irq_m));
    check("bad_write", 64'(o_bad_write), 64'(badw_m));
    exp_rd = model_read(bus.i_mem_addr);
    if (!$isunknown(exp_rd)) check("rdata", 64'(bus.o_mem_rdata), 64'(exp_rd));
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] m, input logic ready);
    bus.i_mem_we    = we;
    bus.i_mem_addr  = a;
    bus.i_mem_wdata = d;
    bus.i_mem_wmask = m;
    bus.i_tx_ready  = ready;
  endtask

  // One cycle: apply inputs, check outputs against the model, take the edge, update model.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] m, input logic ready);
    drive(we, a, d, m, ready);
    #1;
    compare_outputs();
    @(posedge i_clk);
    model_update(we, a, d, m, ready);
    #1;
  endtask

  function automatic logic [31:0] pick_mask(input int sel);
    case (sel)
      0: return 32'hFFFF_FFFF;
      1: return 32'h0000_00FF;
      2: return 32'h0000_FF00;
      3: return 32'hFF00_0000;
      4: return 32'h0000_FFFF;
      default: return 32'hFFFF_0000;
    endcase
  endfunction

  initial begin
    logic [31:0] a, m;
    drive(1'b0, MB + 32'h4, 32'h0, 32'h0, 1'b0);
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;

    // Reset values, read while reset is still asserted
    check("rst_tx_valid", 64'(bus.o_tx_valid), 64'd0);
    check("rst_irq", 64'(o_timer_irq), 64'd0);
    check("rst_bad_write", 64'(o_bad_write), 64'd0);
    check("rst_con_stat", 64'(bus.o_mem_rdata), 64'h0002_0000);
    bus.i_mem_addr = MB + 32'h10; #1;
    check("rst_cmp_lo", 64'(bus.o_mem_rdata), 64'hFFFF_FFFF);
    bus.i_mem_addr = MB + 32'h14; #1;
    check("rst_cmp_hi", 64'(bus.o_mem_rdata), 64'hFFFF_FFFF);
    bus.i_mem_addr = MB + 32'h8; #1;
    check("rst_mtime_lo", 64'(bus.o_mem_rdata), 64'h0);
    i_rst_n = 1'b1;

    // RAM masked merge
    step(1'b1, DB + 32'h8, 32'h1122_3344, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, DB + 32'h8, 32'h0000_AA00, 32'h0000_FF00, 1'b0);
    step(1'b0, DB + 32'h8, 32'h0, 32'h0, 1'b0);
    check("ram_merge", 64'(bus.o_mem_rdata), 64'h1122_AA44);

    // Console: two bytes held, then drained on consecutive cycles
    step(1'b1, MB, 32'h48, 32'hFF, 1'b0);
    step(1'b1, MB, 32'h69, 32'hFF, 1'b0);
    step(1'b0, MB + 32'h4, 32'h0, 32'h0, 1'b0);
    check("con_stat_two", 64'(bus.o_mem_rdata), 64'h0000_0002);
    check("con_head_48", 64'(bus.o_tx_data), 64'h48);
    step(1'b0, MB + 32'h4, 32'h0, 32'h0, 1'b1);
    check("con_head_69", 64'(bus.o_tx_data), 64'h69);
    step(1'b0, MB + 32'h4, 32'h0, 32'h0, 1'b1);
    check("con_drained", 64'(bus.o_tx_valid), 64'd0);

    // Overflow: nine pushes into eight entries, then W1C
    for (int i = 0; i < 9; i++) step(1'b1, MB, 32'(8'hA0 + i), 32'hFF, 1'b0);
    step(1'b0, MB + 32'h4, 32'h0, 32'h0, 1'b0);
    check("ovf_stat", 64'(bus.o_mem_rdata), 64'h0101_0008);
    step(1'b1, MB + 32'h4, 32'h0100_0000, 32'h0100_0000, 1'b0);
    check("ovf_w1c", 64'(bus.o_mem_rdata), 64'h0001_0008);

    // Full + pop + push in the same cycle
    step(1'b1, MB, 32'hEE, 32'hFF, 1'b1);
    step(1'b0, MB + 32'h4, 32'h0, 32'h0, 1'b0);
    check("fpp_stat", 64'(bus.o_mem_rdata), 64'h0001_0008);
    check("fpp_head", 64'(bus.o_tx_data), 64'hA1);
    repeat (7) step(1'b0, MB + 32'h4, 32'h0, 32'h0, 1'b1);
    check("fpp_last_byte", 64'(bus.o_tx_data), 64'hEE);
    step(1'b0, MB + 32'h4, 32'h0, 32'h0, 1'b1);
    check("fpp_empty", 64'(bus.o_tx_valid), 64'd0);

    // Unmapped store
    step(1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
    check("bad_write_pulse", 64'(o_bad_write), 64'd1);
    check("unmapped_rdata", 64'(bus.o_mem_rdata), 64'h0);
    step(1'b0, MB + 32'h4, 32'h0, 32'h0, 1'b0);
    check("bad_write_single", 64'(o_bad_write), 64'd0);

    // Timer compare at 100
    step(1'b1, MB + 32'h14, 32'h0, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, MB + 32'h10, 32'd100, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, MB + 32'hC, 32'h0, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, MB + 32'h8, 32'h0, 32'hFFFF_FFFF, 1'b0);
    repeat (100) step(1'b0, MB + 32'h8, 32'h0, 32'h0, 1'b0);
    check("timer_at_100", 64'(bus.o_mem_rdata), 64'd100);
    check("irq_not_yet", 64'(o_timer_irq), 64'd0);
    step(1'b0, MB + 32'h8, 32'h0, 32'h0, 1'b0);
    check("irq_rise", 64'(o_timer_irq), 64'd1);

    // Carry from MTIME_LO into MTIME_HI
    step(1'b1, MB + 32'hC, 32'h0, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, MB + 32'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, MB + 32'hC, 32'h0, 32'h0, 1'b0);
    check("mtime_carry", 64'(bus.o_mem_rdata), 64'd1);

    // Randomized traffic: seed the RAM words used, then mixed accesses
    for (int i = 0; i < 16; i++) step(1'b1, DB + 32'(4 * i), $urandom, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, DB + 32'(4 * (DW - 1)), $urandom, 32'hFFFF_FFFF, 1'b0);
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = DB + 32'(4 * $urandom_range(0, 15));
        2:       a = DB + 32'(4 * (DW - 1));
        3, 4:    a = MB + 32'(4 * $urandom_range(0, 7));
        default: begin
          case ($urandom_range(0, 3))
            0:       a = DB - 32'h4;
            1:       a = DB + 32'(DW * 4);
            2:       a = 32'h2000_0000;
            default: a = MB + 32'h1000;
          endcase
        end
      endcase
      a = a | 32'($urandom_range(0, 3));
      m = pick_mask(int'($urandom_range(0, 5)));
      step($urandom_range(0, 2) == 0, a, $urandom, m, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a drain
    drive(1'b0, DB, 32'h0, 32'h0, 1'b0);
    @(posedge i_clk); model_update(1'b0, DB, 32'h0, 32'h0, 1'b0); #1;
    while (fifo_m.size() > 0) step(1'b0, DB, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, MB, 32'(8'h30 + i), 32'hFF, 1'b0);
    drive(1'b0, DB, 32'h0, 32'h0, 1'b1);
    @(posedge i_clk); model_update(1'b0, DB, 32'h0, 32'h0, 1'b1);
    #2;
    check("pre_rst_valid", 64'(bus.o_tx_valid), 64'd1);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.o_tx_valid), 64'd0);
    model_reset();
    drive(1'b0, MB + 32'h4, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step(1'b0, MB + 32'h4, 32'h0, 32'h0, 1'b0);
    check("post_rst_stat", 64'(bus.o_mem_rdata), 64'h0002_0000);
    step(1'b0, MB + 32'h8, 32'h0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
